iob_eth_rx_frame_wr: RTL and testbench



---
 rtl/iob_eth_rx_frame_wr_pkg.sv | 22 ++
 rtl/iob_eth_gray_sync.sv | 37 +++
 rtl/iob_eth_rx_frame_wr.sv | 190 +++++++++++++++++++
 tb/tb_iob_eth_rx_frame_wr.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_rx_frame_wr_pkg.sv
// Shared definitions for the Ethernet RX frame writer: FSM states, header and
// payload limits, statistics counter width and a saturating increment helper.
package iob_eth_rx_frame_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_DROP,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_COMMIT
  } state_t;

  localparam int HDR_LEN = 2;
  localparam int MAX_LEN = 2047;
  localparam int CNT_W   = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/iob_eth_gray_sync.sv
// Multi-stage synchronizer for a Gray-coded pointer followed by Gray->binary
// conversion. NEGEDGE selects the active clock edge of the destination domain.
module iob_eth_gray_sync #(
  parameter int W        = 13,
  parameter int STAGES   = 2,
  parameter bit NEGEDGE  = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] bin_out
);

  logic [STAGES-1:0][W-1:0] sync_q, sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = gray_in;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  if (NEGEDGE) begin : g_neg
    always_ff @(negedge clk or negedge rstn)
      if (!rstn) sync_q <= '0;
      else       sync_q <= sync_d;
  end else begin : g_pos
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) sync_q <= '0;
      else       sync_q <= sync_d;
  end

  // Each binary bit is the XOR of all Gray bits at and above it.
  for (genvar i = 0; i < W; i++) begin : g_bin
    assign bin_out[i] = ^(sync_q[STAGES-1] >> i);
  end

endmodule

// File: rtl/iob_eth_rx_frame_wr.sv
// RX_CLK-domain frame writer: stores received bytes behind a 2-byte length header
// in a circular buffer and publishes the committed pointer in Gray code.
// Statistics counters exist only when IOB_ETH_RX_STATS_EN is defined.
module iob_eth_rx_frame_wr
  import iob_eth_rx_frame_wr_pkg::*;
#(
  parameter int BUF_AW      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              RX_CLK,
  input  logic              rx_rstn,
  input  logic              in_start,
  input  logic              in_wr,
  input  logic [7:0]        in_data,
  input  logic              in_end,
  input  logic              in_crc_ok,
  output logic              mem_we,
  output logic [BUF_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [BUF_AW:0]   rd_ptr_gray,
  output logic [BUF_AW:0]   wr_ptr_gray,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int PW = BUF_AW + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {BUF_AW{1'b0}}};

  state_t            state_q, state_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     tent_ptr_q, tent_ptr_d;
  logic [10:0]       len_q, len_d;
  logic              mem_we_q, mem_we_d;
  logic [BUF_AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [PW-1:0]     wr_ptr_gray_q, wr_ptr_gray_d;
  logic              overflow_q, overflow_d;
  logic [PW-1:0]     rd_ptr_bin, used_tent, used_commit;
  logic              full, room, do_start, frame_inc, drop_inc;

  iob_eth_gray_sync #(.W(PW), .STAGES(SYNC_STAGES), .NEGEDGE(1'b1)) u_rd_sync (
    .clk     (RX_CLK),
    .rstn    (rx_rstn),
    .gray_in (rd_ptr_gray),
    .bin_out (rd_ptr_bin)
  );

  // A new frame starts from the committed pointer, so room is judged there.
  assign used_tent   = tent_ptr_q - rd_ptr_bin;
  assign used_commit = commit_ptr_q - rd_ptr_bin;
  assign full        = (used_tent == DEPTH);
  assign room        = ((DEPTH - used_commit) >= PW'(HDR_LEN));

  always_comb begin
    state_d       = state_q;
    commit_ptr_d  = commit_ptr_q;
    tent_ptr_d    = tent_ptr_q;
    len_d         = len_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wr_ptr_gray_d = wr_ptr_gray_q;
    overflow_d    = overflow_q;
    do_start      = 1'b0;
    frame_inc     = 1'b0;
    drop_inc      = 1'b0;

    case (state_q)
      ST_IDLE: do_start = in_start;
      ST_DATA, ST_DROP: begin
        if (in_start) begin
          drop_inc = 1'b1;
          do_start = 1'b1;
        end else if (in_wr && state_q == ST_DATA) begin
          if (full || len_q == 11'(MAX_LEN)) begin
            state_d = ST_DROP;
            if (full) overflow_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = tent_ptr_q[BUF_AW-1:0];
            mem_wdata_d = in_data;
            tent_ptr_d  = tent_ptr_q + PW'(1);
            len_d       = len_q + 11'd1;
          end
        end else if (in_end) begin
          if (state_q == ST_DATA && in_crc_ok && len_q != 11'd0) begin
            state_d = ST_HDR_HI;
          end else begin
            tent_ptr_d = commit_ptr_q;
            drop_inc   = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HDR_HI: begin
        drop_inc    = in_start;
        mem_we_d    = 1'b1;
        mem_addr_d  = commit_ptr_q[BUF_AW-1:0];
        mem_wdata_d = {5'b0, len_q[10:8]};
        state_d     = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        drop_inc    = in_start;
        mem_we_d    = 1'b1;
        mem_addr_d  = commit_ptr_q[BUF_AW-1:0] + BUF_AW'(1);
        mem_wdata_d = len_q[7:0];
        state_d     = ST_COMMIT;
      end
      ST_COMMIT: begin
        drop_inc      = in_start;
        commit_ptr_d  = tent_ptr_q;
        wr_ptr_gray_d = tent_ptr_q ^ (tent_ptr_q >> 1);
        frame_inc     = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_start) begin
      if (room) begin
        tent_ptr_d = commit_ptr_q + PW'(HDR_LEN);
        len_d      = 11'd0;
        state_d    = ST_DATA;
      end else begin
        tent_ptr_d = commit_ptr_q;
        overflow_d = 1'b1;
        state_d    = ST_DROP;
      end
    end
  end

  always_ff @(negedge RX_CLK or negedge rx_rstn) begin
    if (!rx_rstn) begin
      state_q       <= ST_IDLE;
      commit_ptr_q  <= '0;
      tent_ptr_q    <= '0;
      len_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wr_ptr_gray_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_ptr_q  <= commit_ptr_d;
      tent_ptr_q    <= tent_ptr_d;
      len_q         <= len_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      overflow_q    <= overflow_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign overflow    = overflow_q;

`ifdef IOB_ETH_RX_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = sat_inc(frame_cnt_q, frame_inc);
    drop_cnt_d  = sat_inc(drop_cnt_q, drop_inc);
  end

  always_ff @(negedge RX_CLK or negedge rx_rstn) begin
    if (!rx_rstn) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = frame_inc ^ drop_inc;
  assign frame_cnt    = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_iob_eth_rx_frame_wr.sv
// Directed bench: a 4 KiB instance (A) and a 64-byte instance (B) share the
// receiver stimulus; whichever is not under test is held in reset.
module tb_iob_eth_rx_frame_wr;

  logic        clk = 1'b0;
  logic        rstn_a, rstn_b;
  logic        in_start, in_wr, in_end, in_crc_ok;
  logic [7:0]  in_data;
  logic [12:0] a_rd, a_wr_gray;
  logic [6:0]  b_rd, b_wr_gray;
  logic        a_we, b_we, a_ovf, b_ovf;
  logic [11:0] a_addr;
  logic [5:0]  b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic [15:0] a_frame, a_drop, b_frame, b_drop;

  int pass_cnt = 0, chk_cnt = 0;

  always #5 clk = ~clk;

  iob_eth_rx_frame_wr #(.BUF_AW(12), .SYNC_STAGES(2)) dut_a (
    .RX_CLK(clk), .rx_rstn(rstn_a), .in_start(in_start), .in_wr(in_wr),
    .in_data(in_data), .in_end(in_end), .in_crc_ok(in_crc_ok),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .rd_ptr_gray(a_rd), .wr_ptr_gray(a_wr_gray), .overflow(a_ovf),
    .frame_cnt(a_frame), .drop_cnt(a_drop));

  iob_eth_rx_frame_wr #(.BUF_AW(6), .SYNC_STAGES(2)) dut_b (
    .RX_CLK(clk), .rx_rstn(rstn_b), .in_start(in_start), .in_wr(in_wr),
    .in_data(in_data), .in_end(in_end), .in_crc_ok(in_crc_ok),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .rd_ptr_gray(b_rd), .wr_ptr_gray(b_wr_gray), .overflow(b_ovf),
    .frame_cnt(b_frame), .drop_cnt(b_drop));

  // Write monitors on the rising edge, half a cycle after the DUT updates.
  logic [7:0]  a_mem [0:4095];
  logic [7:0]  b_mem [0:63];
  logic [11:0] a_log [0:8191];
  logic [5:0]  b_log [0:1023];
  int a_wecnt = 0, b_wecnt = 0;

  always @(posedge clk) begin
    if (a_we) begin
      a_mem[a_addr] <= a_wdata;
      a_log[a_wecnt % 8192] <= a_addr;
      a_wecnt <= a_wecnt + 1;
    end
    if (b_we) begin
      b_mem[b_addr] <= b_wdata;
      b_log[b_wecnt % 1024] <= b_addr;
      b_wecnt <= b_wecnt + 1;
    end
  end

  function automatic int expc(input int v);
`ifdef IOB_ETH_RX_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic crc, input logic [7:0] seed);
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_wr   = 1'b1;
      in_data = seed + 8'(i);
      tick();
    end
    in_wr     = 1'b0;
    in_end    = 1'b1;
    in_crc_ok = crc;
    tick();
    in_end    = 1'b0;
    in_crc_ok = 1'b0;
  endtask

  initial begin
    int w0, errs;
    in_start = 0; in_wr = 0; in_end = 0; in_crc_ok = 0; in_data = 0;
    a_rd = '0; b_rd = '0; rstn_a = 1'b0; rstn_b = 1'b0;
    tick(); tick();

    chk("rst_wr_gray", 32'(a_wr_gray), 32'h0);
    chk("rst_mem_we",  32'(a_we),      32'h0);
    chk("rst_ovf",     32'(a_ovf),     32'h0);
    chk("rst_frame",   32'(a_frame),   32'h0);
    chk("rst_drop",    32'(a_drop),    32'h0);

    rstn_a = 1'b1;
    tick();

    // Bad FCS: data written and rolled back, no header, pointer unpublished.
    w0 = a_wecnt;
    send_frame(64, 1'b0, 8'h10);
    tick(); tick(); tick();
    chk("bad_we_count",  32'(a_wecnt - w0),    32'd64);
    chk("bad_first_adr", 32'(a_log[w0 % 8192]), 32'd2);
    chk("bad_wr_gray",   32'(a_wr_gray),        32'h0);
    chk("bad_drop",      32'(a_drop),           32'(expc(1)));

    // Good 64-byte frame reuses the rolled-back space.
    w0 = a_wecnt;
    send_frame(64, 1'b1, 8'h20);
    tick(); tick();
    chk("good_gray_early", 32'(a_wr_gray), 32'h0);
    tick();
    chk("good_wr_gray",   32'(a_wr_gray), 32'h63);
    chk("good_we_count",  32'(a_wecnt - w0), 32'd66);
    chk("good_first_adr", 32'(a_log[w0 % 8192]), 32'd2);
    chk("good_last_adr",  32'(a_log[(w0 + 63) % 8192]), 32'd65);
    chk("good_hdr_adr0",  32'(a_log[(w0 + 64) % 8192]), 32'd0);
    chk("good_hdr_adr1",  32'(a_log[(w0 + 65) % 8192]), 32'd1);
    chk("good_hdr_hi",    32'(a_mem[0]), 32'h00);
    chk("good_hdr_lo",    32'(a_mem[1]), 32'h40);
    errs = 0;
    for (int i = 0; i < 64; i++) if (a_mem[2 + i] !== 8'h20 + 8'(i)) errs++;
    chk("good_payload_errs", 32'(errs), 32'd0);
    chk("good_frame",     32'(a_frame), 32'(expc(1)));
    chk("good_ovf",       32'(a_ovf),   32'h0);

    // 2048-byte frame: byte 2048 exceeds the length limit.
    w0 = a_wecnt;
    send_frame(2048, 1'b1, 8'h00);
    tick(); tick(); tick();
    chk("long_we_count", 32'(a_wecnt - w0), 32'd2047);
    chk("long_wr_gray",  32'(a_wr_gray), 32'h63);
    chk("long_drop",     32'(a_drop),    32'(expc(2)));
    chk("long_frame",    32'(a_frame),   32'(expc(1)));
    chk("long_ovf",      32'(a_ovf),     32'h0);

    // Reset while a byte write is being presented.
    in_start = 1'b1; tick(); in_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_wr = 1'b1; in_data = 8'hA0 + 8'(i); tick();
    end
    chk("pre_rst_we", 32'(a_we), 32'h1);
    rstn_a = 1'b0;
    #1;
    chk("midrst_we",    32'(a_we),      32'h0);
    chk("midrst_addr",  32'(a_addr),    32'h0);
    chk("midrst_wdata", 32'(a_wdata),   32'h0);
    chk("midrst_gray",  32'(a_wr_gray), 32'h0);
    chk("midrst_frame", 32'(a_frame),   32'h0);
    chk("midrst_drop",  32'(a_drop),    32'h0);
    in_wr = 1'b0;
    tick();
    rstn_a = 1'b1;
    tick();
    w0 = a_wecnt;
    send_frame(4, 1'b1, 8'h55);
    tick(); tick(); tick();
    chk("post_rst_data0", 32'(a_log[w0 % 8192]), 32'd2);
    chk("post_rst_hdr0",  32'(a_log[(w0 + 4) % 8192]), 32'd0);
    chk("post_rst_gray",  32'(a_wr_gray), 32'h5);

    // Small buffer, reader idle: 70-byte frame overflows on byte 63.
    rstn_a = 1'b0;
    rstn_b = 1'b1;
    tick();
    w0 = b_wecnt;
    send_frame(70, 1'b1, 8'h30);
    tick(); tick(); tick();
    chk("ovf_we_count", 32'(b_wecnt - w0), 32'd62);
    chk("ovf_last_adr", 32'(b_log[(w0 + 61) % 1024]), 32'd63);
    chk("ovf_flag",     32'(b_ovf),     32'h1);
    chk("ovf_wr_gray",  32'(b_wr_gray), 32'h0);
    chk("ovf_drop",     32'(b_drop),    32'(expc(1)));

    // Move the commit pointer to 62, then let the reader catch up.
    send_frame(60, 1'b1, 8'h40);
    tick(); tick(); tick();
    chk("pre_wrap_gray", 32'(b_wr_gray), 32'h21);
    b_rd = 7'h21;
    tick(); tick(); tick(); tick();

    // Header straddles the top of the buffer, payload wraps to 0.
    w0 = b_wecnt;
    send_frame(10, 1'b1, 8'h70);
    tick(); tick(); tick();
    chk("wrap_wr_gray",  32'(b_wr_gray), 32'h6F);
    chk("wrap_bit",      32'(b_wr_gray[6]), 32'h1);
    chk("wrap_data0_ad", 32'(b_log[w0 % 1024]), 32'd0);
    chk("wrap_data9_ad", 32'(b_log[(w0 + 9) % 1024]), 32'd9);
    chk("wrap_hdr_ad0",  32'(b_log[(w0 + 10) % 1024]), 32'd62);
    chk("wrap_hdr_ad1",  32'(b_log[(w0 + 11) % 1024]), 32'd63);
    chk("wrap_hdr_hi",   32'(b_mem[62]), 32'h00);
    chk("wrap_hdr_lo",   32'(b_mem[63]), 32'h0A);
    chk("wrap_byte0",    32'(b_mem[0]),  32'h70);
    chk("wrap_byte9",    32'(b_mem[9]),  32'h79);
    chk("wrap_frame",    32'(b_frame),   32'(expc(2)));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
